// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared state type and parameter helpers for the fixed-point square root
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int iter_f(input int width, input int fbits);
    return (width + fbits) / 2;
  endfunction

  function automatic int cycles_f(input int width, input int fbits, input int steps);
    return iter_f(width, fbits) / steps;
  endfunction

  function automatic int cnt_w_f(input int width, input int fbits, input int steps);
    int c;
    c = cycles_f(width, fbits, steps);
    return (c <= 2) ? 1 : $clog2(c);
  endfunction

  function automatic bit params_ok(input int width, input int fbits, input int steps);
    return ((width + fbits) % 2 == 0) && (steps > 0) && (iter_f(width, fbits) % steps == 0);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one combinational restoring step: resolves a single root bit
module sqrt_step #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic [WIDTH+1:0]       ac,
  input  logic [WIDTH+FBITS-1:0] x,
  input  logic [WIDTH-1:0]       q,
  output logic [WIDTH+1:0]       ac_next,
  output logic [WIDTH+FBITS-1:0] x_next,
  output logic [WIDTH-1:0]       q_next
);

  localparam int XW = WIDTH + FBITS;

  logic [WIDTH+1:0] ac_sh;
  logic [WIDTH+1:0] t;
  logic             unused_bits;

  assign ac_sh   = {ac[WIDTH-1:0], x[XW-1:XW-2]};
  assign t       = ac_sh - {q, 2'b01};
  assign x_next  = {x[XW-3:0], 2'b00};
  // sign bit of t decides whether the trial subtraction is kept
  assign ac_next = t[WIDTH+1] ? ac_sh : t;
  assign q_next  = {q[WIDTH-2:0], ~t[WIDTH+1]};

  // remainder and root never grow into these bits for legal parameters
  assign unused_bits = ^{ac[WIDTH+1:WIDTH], q[WIDTH-1]};

endmodule

// File: rtl/sqrt_pipe_fx.sv
// rtl/sqrt_pipe_fx.sv - iterative fixed-point square root with valid/ready handshakes
module sqrt_pipe_fx
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FBITS = 16,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rad,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] root,
  output logic [WIDTH+1:0] rem,
  output logic             busy
);

  localparam int XW     = WIDTH + FBITS;
  localparam int CYCLES = cycles_f(WIDTH, FBITS, STEPS);
  localparam int CNT_W  = cnt_w_f(WIDTH, FBITS, STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  if (!params_ok(WIDTH, FBITS, STEPS)) begin : g_bad_params
    $error("sqrt_pipe_fx: WIDTH+FBITS must be even and STEPS must divide (WIDTH+FBITS)/2");
  end

  state_e           state_q, state_d;
  logic [WIDTH+1:0] ac_q, ac_d;
  logic [XW-1:0]    x_q, x_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] root_q, root_d;
  logic [WIDTH+1:0] rem_q, rem_d;
  logic             load;

  logic [WIDTH+1:0] ac_c [STEPS+1];
  logic [XW-1:0]    x_c  [STEPS+1];
  logic [WIDTH-1:0] q_c  [STEPS+1];

  assign ac_c[0] = ac_q;
  assign x_c[0]  = x_q;
  assign q_c[0]  = q_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    sqrt_step #(
      .WIDTH(WIDTH),
      .FBITS(FBITS)
    ) u_step (
      .ac      (ac_c[g]),
      .x       (x_c[g]),
      .q       (q_c[g]),
      .ac_next (ac_c[g+1]),
      .x_next  (x_c[g+1]),
      .q_next  (q_c[g+1])
    );
  end

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign root      = root_q;
  assign rem       = rem_q;

  always_comb begin
    state_d = state_q;
    ac_d    = ac_q;
    x_d     = x_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    rem_d   = rem_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: load = in_valid;
      CALC: begin
        ac_d  = ac_c[STEPS];
        x_d   = x_c[STEPS];
        q_d   = q_c[STEPS];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          root_d  = q_c[STEPS];
          rem_d   = ac_c[STEPS];
        end
      end
      DONE: begin
        if (out_ready) begin
          // back-to-back accept keeps throughput at one result per CYCLES+1
          if (in_valid) load = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = CALC;
      x_d     = {rad, {FBITS{1'b0}}};
      ac_d    = '0;
      q_d     = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ac_q    <= '0;
      x_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      x_q     <= x_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

endmodule
